// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// mem_access_pkg : load/store op codes, exception bits and FSM states
// Rev 1.0
// ============================================================================
package mem_access_pkg;

  localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
  localparam logic [7:0] EXE_LB_OP  = 8'b11100000;
  localparam logic [7:0] EXE_LH_OP  = 8'b11100001;
  localparam logic [7:0] EXE_LW_OP  = 8'b11100011;
  localparam logic [7:0] EXE_LBU_OP = 8'b11100100;
  localparam logic [7:0] EXE_LHU_OP = 8'b11100101;
  localparam logic [7:0] EXE_SB_OP  = 8'b11101000;
  localparam logic [7:0] EXE_SH_OP  = 8'b11101001;
  localparam logic [7:0] EXE_SW_OP  = 8'b11101011;

  localparam int EXC_ADEL   = 13;
  localparam int EXC_ADES   = 14;
  localparam int EXC_BUSERR = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/mem_access_lane.sv
`default_nettype none
// ============================================================================
// mem_lane : big-endian byte-lane steering, load extension, alignment check
// Rev 1.0
// ============================================================================
module mem_lane
  import mem_access_pkg::*;
(
  input  logic [7:0]  aluop_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] reg2_i,
  input  logic [31:0] rdata_i,
  output logic        is_mem_o,
  output logic        is_store_o,
  output logic        misaligned_o,
  output logic [3:0]  sel_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_o
);

  logic [3:0]  byte_sel;
  logic [3:0]  half_sel;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Address 0 is the most significant byte of the word.
  assign byte_sel = 4'b1000 >> addr_lo_i;
  assign half_sel = addr_lo_i[1] ? 4'b0011 : 4'b1100;
  assign half_v   = addr_lo_i[1] ? rdata_i[15:0] : rdata_i[31:16];

  always_comb begin
    byte_v = rdata_i[31:24];
    case (addr_lo_i)
      2'd1:    byte_v = rdata_i[23:16];
      2'd2:    byte_v = rdata_i[15:8];
      2'd3:    byte_v = rdata_i[7:0];
      default: byte_v = rdata_i[31:24];
    endcase
  end

  always_comb begin
    is_mem_o     = 1'b1;
    is_store_o   = 1'b0;
    misaligned_o = 1'b0;
    sel_o        = 4'b0000;
    wdata_o      = reg2_i;
    load_o       = rdata_i;
    case (aluop_i)
      EXE_LB_OP: begin
        sel_o  = byte_sel;
        load_o = {{24{byte_v[7]}}, byte_v};
      end
      EXE_LBU_OP: begin
        sel_o  = byte_sel;
        load_o = {24'b0, byte_v};
      end
      EXE_LH_OP: begin
        sel_o        = half_sel;
        misaligned_o = addr_lo_i[0];
        load_o       = {{16{half_v[15]}}, half_v};
      end
      EXE_LHU_OP: begin
        sel_o        = half_sel;
        misaligned_o = addr_lo_i[0];
        load_o       = {16'b0, half_v};
      end
      EXE_LW_OP: begin
        sel_o        = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      EXE_SB_OP: begin
        is_store_o = 1'b1;
        sel_o      = byte_sel;
        wdata_o    = {4{reg2_i[7:0]}};
      end
      EXE_SH_OP: begin
        is_store_o   = 1'b1;
        sel_o        = half_sel;
        misaligned_o = addr_lo_i[0];
        wdata_o      = {2{reg2_i[15:0]}};
      end
      EXE_SW_OP: begin
        is_store_o   = 1'b1;
        sel_o        = 4'b1111;
        misaligned_o = |addr_lo_i;
      end
      default: is_mem_o = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
// mem_access : MIPS32 MEM stage, one req/ack bus transaction per load/store
// Rev 1.0
// ============================================================================
module mem_access
  import mem_access_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [7:0]  aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  output logic        stallreq,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic [31:0] excepttype_o
);

  localparam logic [31:0] TO_LAST = (BUS_TIMEOUT == 0) ? 32'd0 : 32'(BUS_TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] cnt_q;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_sel_q;
  logic [4:0]  wd_q;
  logic        wreg_q;
  logic [31:0] rdata_q, exc_q;

  logic        is_mem, is_store, misaligned, start, timeout;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata, lane_load;
  logic        unused_stall;

  assign unused_stall = ^{stall[5], stall[3:0]};

  mem_lane u_lane (
    .aluop_i      (aluop_i),
    .addr_lo_i    (mem_addr_i[1:0]),
    .reg2_i       (reg2_i),
    .rdata_i      (bus_rdata),
    .is_mem_o     (is_mem),
    .is_store_o   (is_store),
    .misaligned_o (misaligned),
    .sel_o        (lane_sel),
    .wdata_o      (lane_wdata),
    .load_o       (lane_load)
  );

  assign start   = is_mem && !flush && (excepttype_i == 32'd0) && !misaligned;
  assign timeout = (BUS_TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
      wd_q        <= '0;
      wreg_q      <= 1'b0;
      rdata_q     <= '0;
      exc_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          bus_req_q   <= 1'b1;
          bus_we_q    <= is_store;
          bus_addr_q  <= {mem_addr_i[31:2], 2'b00};
          bus_sel_q   <= lane_sel;
          bus_wdata_q <= lane_wdata;
          wd_q        <= wd_i;
          wreg_q      <= wreg_i & ~is_store;
          exc_q       <= excepttype_i;
          cnt_q       <= '0;
          state_q     <= ST_BUSY;
        end
        ST_BUSY: begin
          // An ack completes the bus cycle even when a flush arrives with it.
          if (bus_ack) begin
            bus_req_q <= 1'b0;
            rdata_q   <= lane_load;
            state_q   <= flush ? ST_IDLE : ST_DONE;
          end else if (timeout) begin
            bus_req_q         <= 1'b0;
            exc_q[EXC_BUSERR] <= 1'b1;
            wreg_q            <= 1'b0;
            state_q           <= flush ? ST_IDLE : ST_DONE;
          end else if (flush) begin
            state_q <= ST_DRAIN;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_DONE: if (!stall[4] || flush) state_q <= ST_IDLE;
        ST_DRAIN: if (bus_ack) begin
          bus_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;

  always_comb begin
    stallreq     = 1'b0;
    wd_o         = wd_i;
    wreg_o       = wreg_i;
    wdata_o      = wdata_i;
    excepttype_o = excepttype_i;
    case (state_q)
      ST_IDLE: if (is_mem && !flush) begin
        wreg_o = 1'b0;
        if (excepttype_i == 32'd0) begin
          if (misaligned) excepttype_o[is_store ? EXC_ADES : EXC_ADEL] = 1'b1;
          else            stallreq = 1'b1;
        end
      end
      ST_BUSY: begin
        stallreq = 1'b1;
        wreg_o   = 1'b0;
      end
      ST_DONE: if (!flush) begin
        wd_o         = wd_q;
        wreg_o       = wreg_q;
        wdata_o      = rdata_q;
        excepttype_o = exc_q;
      end
      ST_DRAIN: begin
        stallreq = start;
        wreg_o   = 1'b0;
      end
      default: stallreq = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
// ============================================================================
// tb_mem_access : directed vector table plus multi-cycle corner sequences
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mem_access;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [7:0]  aluop;
  logic [31:0] mem_addr, reg2, wdata_in, exc_in, rdata;
  logic [4:0]  wd_in;
  logic        wreg_in, ack;
  logic        bus_req, bus_we, stallreq, wreg_o;
  logic [31:0] bus_addr, bus_wdata, wdata_o, exc_o;
  logic [3:0]  bus_sel;
  logic [4:0]  wd_o;

  always #5 clk = ~clk;

  mem_access #(.BUS_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .aluop_i(aluop), .mem_addr_i(mem_addr), .reg2_i(reg2), .wd_i(wd_in),
    .wreg_i(wreg_in), .wdata_i(wdata_in), .excepttype_i(exc_in),
    .bus_rdata(rdata), .bus_ack(ack),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_sel(bus_sel),
    .bus_wdata(bus_wdata), .stallreq(stallreq), .wd_o(wd_o), .wreg_o(wreg_o),
    .wdata_o(wdata_o), .excepttype_o(exc_o)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    int          delay;
    bit          misal;
    logic [3:0]  sel;
    bit          we;
    logic [31:0] bwd;
    logic [31:0] wdo;
    bit          wreg;
    logic [31:0] exc;
  } vec_t;

  vec_t vecs[13];

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] r2);
    aluop = op; mem_addr = addr; reg2 = r2; wd_in = 5'd7; wreg_in = 1'b1;
    wdata_in = 32'h11111111; exc_in = '0; flush = 1'b0; stall = '0; ack = 1'b0; rdata = '0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(posedge clk); #1;
    set_op(v.op, v.addr, v.reg2);
    @(negedge clk);
    if (v.misal) begin
      chk($sformatf("v%0d misal stallreq", i), 32'(stallreq), 32'd0);
      chk($sformatf("v%0d misal bus_req", i), 32'(bus_req), 32'd0);
      chk($sformatf("v%0d misal wreg_o", i), 32'(wreg_o), 32'd0);
      chk($sformatf("v%0d misal excepttype_o", i), exc_o, v.exc);
      return;
    end
    chk($sformatf("v%0d idle stallreq", i), 32'(stallreq), 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d bus_req", i), 32'(bus_req), 32'd1);
    chk($sformatf("v%0d bus_we", i), 32'(bus_we), 32'(v.we));
    chk($sformatf("v%0d bus_sel", i), 32'(bus_sel), 32'(v.sel));
    chk($sformatf("v%0d bus_addr", i), bus_addr, {v.addr[31:2], 2'b00});
    chk($sformatf("v%0d bus_wdata", i), bus_wdata, v.bwd);
    repeat (v.delay) @(negedge clk);
    chk($sformatf("v%0d busy stallreq", i), 32'(stallreq), 32'd1);
    ack = 1'b1; rdata = v.rdata;
    @(posedge clk); #1;
    ack = 1'b0; rdata = '0;
    @(negedge clk);
    chk($sformatf("v%0d done stallreq", i), 32'(stallreq), 32'd0);
    chk($sformatf("v%0d done bus_req", i), 32'(bus_req), 32'd0);
    chk($sformatf("v%0d done wreg_o", i), 32'(wreg_o), 32'(v.wreg));
    chk($sformatf("v%0d done wd_o", i), 32'(wd_o), 32'd7);
    chk($sformatf("v%0d done excepttype_o", i), exc_o, v.exc);
    if (v.wreg) chk($sformatf("v%0d done wdata_o", i), wdata_o, v.wdo);
  endtask

  initial begin
    //          op          addr          reg2          rdata         dly mis sel      we bus_wdata     wdata_o       wreg exc
    vecs[0]  = '{EXE_LW_OP,  32'h00001000, 32'hCAFEF00D, 32'hDEADBEEF, 0, 0, 4'b1111, 0, 32'hCAFEF00D, 32'hDEADBEEF, 1, 32'h0};
    vecs[1]  = '{EXE_LB_OP,  32'h00001001, 32'h00000000, 32'h1280FF00, 0, 0, 4'b0100, 0, 32'h00000000, 32'hFFFFFF80, 1, 32'h0};
    vecs[2]  = '{EXE_LBU_OP, 32'h00001001, 32'h00000000, 32'h1280FF00, 0, 0, 4'b0100, 0, 32'h00000000, 32'h00000080, 1, 32'h0};
    vecs[3]  = '{EXE_SH_OP,  32'h00002002, 32'h0000ABCD, 32'h00000000, 0, 0, 4'b0011, 1, 32'hABCDABCD, 32'h0,        0, 32'h0};
    vecs[4]  = '{EXE_LH_OP,  32'h00002000, 32'h00000000, 32'h80011234, 1, 0, 4'b1100, 0, 32'h00000000, 32'hFFFF8001, 1, 32'h0};
    vecs[5]  = '{EXE_LHU_OP, 32'h00002002, 32'h00000000, 32'h8001F234, 0, 0, 4'b0011, 0, 32'h00000000, 32'h0000F234, 1, 32'h0};
    vecs[6]  = '{EXE_SB_OP,  32'h00000003, 32'h000000A5, 32'h00000000, 0, 0, 4'b0001, 1, 32'hA5A5A5A5, 32'h0,        0, 32'h0};
    vecs[7]  = '{EXE_SW_OP,  32'h00004000, 32'h12345678, 32'h00000000, 2, 0, 4'b1111, 1, 32'h12345678, 32'h0,        0, 32'h0};
    vecs[8]  = '{EXE_LB_OP,  32'h00000000, 32'h00000000, 32'h7F000000, 0, 0, 4'b1000, 0, 32'h00000000, 32'h0000007F, 1, 32'h0};
    vecs[9]  = '{EXE_LW_OP,  32'h00003001, 32'h0,        32'h0,        0, 1, 4'b0000, 0, 32'h0,        32'h0,        0, 32'h00002000};
    vecs[10] = '{EXE_SW_OP,  32'h00003002, 32'h0,        32'h0,        0, 1, 4'b0000, 0, 32'h0,        32'h0,        0, 32'h00004000};
    vecs[11] = '{EXE_LH_OP,  32'h00003003, 32'h0,        32'h0,        0, 1, 4'b0000, 0, 32'h0,        32'h0,        0, 32'h00002000};
    vecs[12] = '{EXE_SH_OP,  32'h00003001, 32'h0,        32'h0,        0, 1, 4'b0000, 0, 32'h0,        32'h0,        0, 32'h00004000};

    rst = 1'b1; stall = '0; flush = 1'b0; aluop = EXE_NOP_OP; mem_addr = '0; reg2 = '0;
    wd_in = '0; wreg_in = 1'b0; wdata_in = '0; exc_in = '0; rdata = '0; ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset bus_req", 32'(bus_req), 32'd0);
    chk("reset bus_we", 32'(bus_we), 32'd0);
    chk("reset bus_addr", bus_addr, 32'd0);
    chk("reset bus_sel", 32'(bus_sel), 32'd0);
    chk("reset bus_wdata", bus_wdata, 32'd0);
    chk("reset stallreq", 32'(stallreq), 32'd0);
    chk("reset wd/wreg/wdata/exc", {wd_o, wreg_o, 26'd0} | wdata_o | exc_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(i);

    // Non-memory op passes straight through.
    @(posedge clk); #1;
    set_op(8'h20, 32'h00000101, 32'h0);
    wd_in = 5'd9; wdata_in = 32'hA5A55A5A; exc_in = 32'h00000200;
    @(negedge clk);
    chk("pass wd_o", 32'(wd_o), 32'd9);
    chk("pass wreg_o", 32'(wreg_o), 32'd1);
    chk("pass wdata_o", wdata_o, 32'hA5A55A5A);
    chk("pass excepttype_o", exc_o, 32'h00000200);
    chk("pass stallreq", 32'(stallreq), 32'd0);

    // Pending exception on an aligned load: no bus cycle.
    @(posedge clk); #1;
    set_op(EXE_LW_OP, 32'h00000100, 32'h0);
    exc_in = 32'h00000200;
    @(negedge clk);
    chk("pend_exc stallreq", 32'(stallreq), 32'd0);
    chk("pend_exc excepttype_o", exc_o, 32'h00000200);
    @(negedge clk);
    chk("pend_exc bus_req", 32'(bus_req), 32'd0);

    // Flush in IDLE: no bus activity.
    @(posedge clk); #1;
    set_op(EXE_LW_OP, 32'h00000100, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    chk("idle_flush stallreq", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    set_op(EXE_NOP_OP, 32'h0, 32'h0);
    @(negedge clk);
    chk("idle_flush bus_req", 32'(bus_req), 32'd0);

    // Flush during BUSY, ack 3 cycles late: DRAIN.
    @(posedge clk); #1;
    set_op(EXE_LW_OP, 32'h00005000, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("drain busy2 stallreq", 32'(stallreq), 32'd1);
    @(posedge clk); #1;
    flush = 1'b0; aluop = EXE_NOP_OP;
    @(negedge clk);
    chk("drain c3 bus_req", 32'(bus_req), 32'd1);
    chk("drain c3 wreg_o", 32'(wreg_o), 32'd0);
    chk("drain c3 stallreq", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    ack = 1'b1; rdata = 32'hBAD0BAD0;
    @(negedge clk);
    chk("drain c4 bus_req", 32'(bus_req), 32'd1);
    chk("drain c4 wreg_o", 32'(wreg_o), 32'd0);
    @(posedge clk); #1;
    ack = 1'b0; rdata = '0;
    @(negedge clk);
    chk("drain end bus_req", 32'(bus_req), 32'd0);
    chk("drain end wreg_o", 32'(wreg_o), 32'd1);
    chk("drain end wdata_o", wdata_o, 32'h11111111);
    run_vec(0);

    // DONE held by stall[4] for 2 cycles.
    @(posedge clk); #1;
    set_op(EXE_LHU_OP, 32'h00006002, 32'h0);
    wd_in = 5'd12;
    @(posedge clk); #1;
    ack = 1'b1; rdata = 32'h1234ABCD;
    @(posedge clk); #1;
    ack = 1'b0; rdata = '0; stall = 6'b011111;
    @(negedge clk);
    chk("hold1 wdata_o", wdata_o, 32'h0000ABCD);
    chk("hold1 wd_o", 32'(wd_o), 32'd12);
    chk("hold1 stallreq", 32'(stallreq), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("hold2 wdata_o", wdata_o, 32'h0000ABCD);
    chk("hold2 wreg_o", 32'(wreg_o), 32'd1);
    @(posedge clk); #1;
    stall = '0;
    @(negedge clk);
    chk("hold3 wdata_o", wdata_o, 32'h0000ABCD);
    @(posedge clk); #1;
    set_op(EXE_NOP_OP, 32'h0, 32'h0);
    wdata_in = 32'h00000077;
    @(negedge clk);
    chk("hold release wdata_o", wdata_o, 32'h00000077);
    chk("hold release bus_req", 32'(bus_req), 32'd0);

    // Ack and flush together in BUSY: straight back to IDLE.
    @(posedge clk); #1;
    set_op(EXE_LW_OP, 32'h00007000, 32'h0);
    @(posedge clk); #1;
    ack = 1'b1; flush = 1'b1; rdata = 32'hFEEDFACE;
    @(posedge clk); #1;
    set_op(EXE_NOP_OP, 32'h0, 32'h0);
    wdata_in = 32'h00000033;
    @(negedge clk);
    chk("ackflush bus_req", 32'(bus_req), 32'd0);
    chk("ackflush wdata_o", wdata_o, 32'h00000033);
    chk("ackflush stallreq", 32'(stallreq), 32'd0);

    // Slave never acks: bus error after 8 BUSY cycles.
    begin
      int cycles;
      cycles = 0;
      @(posedge clk); #1;
      set_op(EXE_LW_OP, 32'h00008000, 32'h0);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (!stallreq) break;
        cycles++;
        @(posedge clk); #1;
      end
      chk("timeout stall cycles", 32'(cycles), 32'd9);
      chk("timeout excepttype_o", exc_o, 32'h00008000);
      chk("timeout wreg_o", 32'(wreg_o), 32'd0);
      chk("timeout bus_req", 32'(bus_req), 32'd0);
    end
    @(posedge clk); #1;
    set_op(EXE_NOP_OP, 32'h0, 32'h0);

    // Reset while BUSY drops the request.
    @(posedge clk); #1;
    set_op(EXE_LW_OP, 32'h00009000, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_mid busy bus_req", 32'(bus_req), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    set_op(EXE_NOP_OP, 32'h0, 32'h0);
    wdata_in = 32'h00000044;
    @(negedge clk);
    chk("rst_mid bus_req", 32'(bus_req), 32'd0);
    chk("rst_mid bus_sel", 32'(bus_sel), 32'd0);
    chk("rst_mid stallreq", 32'(stallreq), 32'd0);
    chk("rst_mid wdata_o", wdata_o, 32'h00000044);
    run_vec(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
